// File: rtl/clock_display_scan.sv
// Six-digit multiplexed HH:MM:SS display driver: scans one digit slot per
// SCAN_DIV cycles, snapshots the time once per frame and converts it to BCD.
module clock_display_scan #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEAD     = 8
) (
  input  logic       ap_clk,
  input  logic       ap_rst_n,
  input  logic [7:0] hh,
  input  logic [7:0] mm,
  input  logic [7:0] ss,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] dig_en,
  output logic       range_err
);

  localparam logic [15:0] PRESC_TC = 16'(SCAN_DIV - 1);
  localparam logic [15:0] DEAD_CNT = 16'(DEAD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV_H = 2'd1,
    CONV_M = 2'd2,
    CONV_S = 2'd3
  } conv_state_e;

  // One double-dabble iteration on {tens, units, binary}; hundreds are never
  // needed because any value above 99 is out of range and shown as a dash.
  function automatic logic [15:0] dabble_step(input logic [15:0] v);
    logic [15:0] a;
    a = v;
    for (int n = 0; n < 2; n++) begin
      if (a[8 + 4*n +: 4] >= 4'd5) a[8 + 4*n +: 4] = a[8 + 4*n +: 4] + 4'd3;
      else                         a[8 + 4*n +: 4] = a[8 + 4*n +: 4];
    end
    return {a[14:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  logic [15:0] presc_q, presc_d;
  logic [2:0]  idx_q, idx_d;
  logic        frame_start_s;
  logic [7:0]  snap_h_q, snap_m_q, snap_s_q;
  conv_state_e state_q, state_d;
  logic [2:0]  iter_q, iter_d;
  logic [15:0] sh_q, sh_d, step_s;
  logic [7:0]  field_s, limit_s;
  logic [1:0]  fld_s;
  // Digit i lives at [4*i +: 4]; digit 0 is hours tens.
  logic [23:0] conv_dig_q, conv_dig_d, disp_dig_q;
  logic [2:0]  conv_err_q, conv_err_d, disp_err_q;
  logic [3:0]  digit_s;
  logic        bad_s;
  logic [5:0]  onehot_s;
  logic [6:0]  seg_d;
  logic        dp_d, range_err_d;
  logic [5:0]  dig_en_d;

  assign frame_start_s = (presc_q == PRESC_TC) && (idx_q == 3'd5);

  // Prescaler and slot index next state
  always_comb begin
    presc_d = presc_q;
    idx_d   = idx_q;
    if (presc_q == PRESC_TC) begin
      presc_d = 16'd0;
      if (idx_q == 3'd5) idx_d = 3'd0;
      else               idx_d = idx_q + 3'd1;
    end else begin
      presc_d = presc_q + 16'd1;
    end
  end

  // Prescaler and slot index registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      presc_q <= 16'd0;
      idx_q   <= 3'd0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  // Conversion FSM: next state and datapath
  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    sh_d       = sh_q;
    conv_dig_d = conv_dig_q;
    conv_err_d = conv_err_q;
    case (state_q)
      CONV_H:  begin field_s = snap_h_q; limit_s = 8'd23; fld_s = 2'd0; end
      CONV_M:  begin field_s = snap_m_q; limit_s = 8'd59; fld_s = 2'd1; end
      CONV_S:  begin field_s = snap_s_q; limit_s = 8'd59; fld_s = 2'd2; end
      default: begin field_s = 8'd0;     limit_s = 8'd0;  fld_s = 2'd0; end
    endcase
    if (iter_q == 3'd0) step_s = dabble_step({8'd0, field_s});
    else                step_s = dabble_step(sh_q);
    if (state_q == IDLE) begin
      iter_d = 3'd0;
      if (frame_start_s) state_d = CONV_H;
      else               state_d = IDLE;
    end else begin
      sh_d   = step_s;
      iter_d = iter_q + 3'd1;
      if (iter_q == 3'd7) begin
        conv_dig_d[{fld_s, 3'b000} +: 8] = {step_s[11:8], step_s[15:12]};
        conv_err_d[fld_s] = (field_s > limit_s);
        case (state_q)
          CONV_H:  state_d = CONV_M;
          CONV_M:  state_d = CONV_S;
          default: state_d = IDLE;
        endcase
      end else begin
        state_d = state_q;
      end
    end
  end

  // Conversion FSM and result registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= IDLE;
      iter_q     <= 3'd0;
      sh_q       <= 16'd0;
      conv_dig_q <= 24'd0;
      conv_err_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      sh_q       <= sh_d;
      conv_dig_q <= conv_dig_d;
      conv_err_q <= conv_err_d;
    end
  end

  // Frame-start snapshot of the inputs and commit of last frame's conversion
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      snap_h_q   <= 8'd0;
      snap_m_q   <= 8'd0;
      snap_s_q   <= 8'd0;
      disp_dig_q <= 24'd0;
      disp_err_q <= 3'd0;
    end else if (frame_start_s) begin
      snap_h_q   <= hh;
      snap_m_q   <= mm;
      snap_s_q   <= ss;
      disp_dig_q <= conv_dig_q;
      disp_err_q <= conv_err_q;
    end else begin
      snap_h_q   <= snap_h_q;
      snap_m_q   <= snap_m_q;
      snap_s_q   <= snap_s_q;
      disp_dig_q <= disp_dig_q;
      disp_err_q <= disp_err_q;
    end
  end

  // Output decode for the current slot
  always_comb begin
    case (idx_q)
      3'd0:    begin digit_s = disp_dig_q[3:0];   bad_s = disp_err_q[0]; onehot_s = 6'b000001; end
      3'd1:    begin digit_s = disp_dig_q[7:4];   bad_s = disp_err_q[0]; onehot_s = 6'b000010; end
      3'd2:    begin digit_s = disp_dig_q[11:8];  bad_s = disp_err_q[1]; onehot_s = 6'b000100; end
      3'd3:    begin digit_s = disp_dig_q[15:12]; bad_s = disp_err_q[1]; onehot_s = 6'b001000; end
      3'd4:    begin digit_s = disp_dig_q[19:16]; bad_s = disp_err_q[2]; onehot_s = 6'b010000; end
      3'd5:    begin digit_s = disp_dig_q[23:20]; bad_s = disp_err_q[2]; onehot_s = 6'b100000; end
      default: begin digit_s = 4'd0;              bad_s = 1'b0;          onehot_s = 6'b000000; end
    endcase
    if (bad_s) seg_d = 7'h40;
    else       seg_d = seg_code(digit_s);
    if (!blank && (presc_q >= DEAD_CNT)) dig_en_d = onehot_s;
    else                                 dig_en_d = 6'd0;
    // Seconds parity equals the parity of its units digit.
    dp_d        = ((idx_q == 3'd1) || (idx_q == 3'd3)) && !disp_dig_q[20];
    range_err_d = |disp_err_q;
  end

  // Registered display outputs
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      seg       <= 7'd0;
      dp        <= 1'b0;
      dig_en    <= 6'd0;
      range_err <= 1'b0;
    end else begin
      seg       <= seg_d;
      dp        <= dp_d;
      dig_en    <= dig_en_d;
      range_err <= range_err_d;
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Self-checking bench for clock_display_scan: a frame-level arithmetic model
// predicts every output cycle by cycle under directed and random stimulus.
module tb_clock_display_scan;

  localparam int SD    = 40;
  localparam int DT    = 4;
  localparam int FRAME = 6 * SD;

  logic       clk;
  logic       rst_n;
  logic [7:0] hh, mm, ss;
  logic       blank;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] dig_en;
  logic       range_err;

  clock_display_scan #(.SCAN_DIV(SD), .DEAD(DT)) dut (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .blank     (blank),
    .seg       (seg),
    .dp        (dp),
    .dig_en    (dig_en),
    .range_err (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int n_vec, n_err;
  int n_edges;
  int sh_h, sh_m, sh_s;
  int pd_h, pd_m, pd_s;
  int en_hi [6];
  int overlap;

  task automatic model_reset();
    n_edges = 0;
    sh_h = 0; sh_m = 0; sh_s = 0;
    pd_h = 0; pd_m = 0; pd_s = 0;
  endtask

  // One clock edge: predict the registered outputs from the displayed frame.
  task automatic tick();
    logic       b, bad;
    int         h, m, s, c, slot, p, val;
    logic [6:0] e_seg;
    logic [5:0] e_en;
    logic       e_dp, e_re;
    b = blank; h = hh; m = mm; s = ss;
    @(posedge clk); #1;
    c = n_edges;
    n_edges++;
    slot = (c / SD) % 6;
    p    = c % SD;
    if (slot < 2)      begin val = sh_h; bad = (sh_h > 23); end
    else if (slot < 4) begin val = sh_m; bad = (sh_m > 59); end
    else               begin val = sh_s; bad = (sh_s > 59); end
    if (bad)                 e_seg = 7'h40;
    else if (slot % 2 == 0)  e_seg = seg_tab[val / 10];
    else                     e_seg = seg_tab[val % 10];
    e_en = (!b && p >= DT) ? 6'(1 << slot) : 6'd0;
    e_dp = (slot == 1 || slot == 3) && (sh_s % 2 == 0);
    e_re = (sh_h > 23) || (sh_m > 59) || (sh_s > 59);
    n_vec++;
    if (seg !== e_seg) begin
      n_err++; $display("FAIL seg edge=%0d slot=%0d got=%h exp=%h", c, slot, seg, e_seg);
    end
    n_vec++;
    if (dig_en !== e_en) begin
      n_err++; $display("FAIL dig_en edge=%0d got=%b exp=%b", c, dig_en, e_en);
    end
    n_vec++;
    if (dp !== e_dp) begin
      n_err++; $display("FAIL dp edge=%0d slot=%0d got=%b exp=%b", c, slot, dp, e_dp);
    end
    n_vec++;
    if (range_err !== e_re) begin
      n_err++; $display("FAIL range_err edge=%0d got=%b exp=%b", c, range_err, e_re);
    end
    for (int i = 0; i < 6; i++) if (dig_en[i] === 1'b1) en_hi[i]++;
    if ($countones(dig_en) > 1) overlap++;
    if (c % FRAME == FRAME - 1) begin
      sh_h = pd_h; sh_m = pd_m; sh_s = pd_s;
      pd_h = h;    pd_m = m;    pd_s = s;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; blank = 1'b0; hh = 8'd0; mm = 8'd0; ss = 8'd0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({seg, dp, dig_en, range_err} !== 15'd0) begin
      n_err++; $display("FAIL reset_async got=%h exp=0", {seg, dp, dig_en, range_err});
    end
    #20 rst_n = 1'b1;
    #1;
    n_vec++;
    if ({seg, dp, dig_en, range_err} !== 15'd0) begin
      n_err++; $display("FAIL reset_release got=%h exp=0", {seg, dp, dig_en, range_err});
    end
    model_reset();
    run(DT);
    n_vec++;
    if (dig_en !== 6'd0) begin
      n_err++; $display("FAIL dead_time got=%b exp=000000", dig_en);
    end
    tick();
    n_vec++;
    if ({dig_en, seg} !== {6'b000001, 7'h3F}) begin
      n_err++; $display("FAIL first_digit got=%b/%h exp=000001/3f", dig_en, seg);
    end
  endtask

  task automatic test_scan();
    hh = 8'd12; mm = 8'd34; ss = 8'd56;
    run(2 * FRAME);
    for (int i = 0; i < 6; i++) en_hi[i] = 0;
    overlap = 0;
    run(FRAME);
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (en_hi[i] !== SD - DT) begin
        n_err++; $display("FAIL en_width bit=%0d got=%0d exp=%0d", i, en_hi[i], SD - DT);
      end
    end
    n_vec++;
    if (overlap !== 0) begin
      n_err++; $display("FAIL en_onehot got=%0d exp=0", overlap);
    end
  endtask

  task automatic test_mm_change();
    while (n_edges % FRAME != FRAME / 2) tick();
    mm = 8'd35;
    run(3 * FRAME);
  endtask

  task automatic test_invalid();
    hh = 8'd24; mm = 8'd0; ss = 8'd7;
    run(3 * FRAME);
    hh = 8'd23; mm = 8'd60; ss = 8'd59;
    run(2 * FRAME);
  endtask

  task automatic test_blank();
    hh = 8'd9; mm = 8'd5; ss = 8'd40;
    while (n_edges % FRAME != 2 * SD + SD / 2) tick();
    blank = 1'b1;
    run(100);
    blank = 1'b0;
    run(FRAME + 50);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        hh = 8'($urandom_range(0, 30));
        mm = 8'($urandom_range(0, 70));
        ss = 8'($urandom_range(0, 99));
      end
      if ($urandom_range(0, 49) == 0) blank = ~blank;
      tick();
    end
    blank = 1'b0;
  endtask

  task automatic test_back_to_back_frames();
    for (int f = 0; f < 4; f++) begin
      while (n_edges % FRAME != 0) tick();
      hh = 8'($urandom_range(0, 23));
      mm = 8'($urandom_range(0, 59));
      ss = 8'($urandom_range(0, 59));
      tick();
    end
    run(2 * FRAME);
  endtask

  task automatic test_reset_mid_conv();
    hh = 8'd17; mm = 8'd48; ss = 8'd21;
    while (n_edges % FRAME != 0) tick();
    run(10);
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({seg, dp, dig_en, range_err} !== 15'd0) begin
      n_err++; $display("FAIL reset_mid_conv got=%h exp=0", {seg, dp, dig_en, range_err});
    end
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    n_vec++;
    if ({seg, dp, dig_en, range_err} !== 15'd0) begin
      n_err++; $display("FAIL reset_hold got=%h exp=0", {seg, dp, dig_en, range_err});
    end
    model_reset();
    run(DT + 1);
    n_vec++;
    if ({dig_en, seg} !== {6'b000001, 7'h3F}) begin
      n_err++; $display("FAIL post_reset_digit got=%b/%h exp=000001/3f", dig_en, seg);
    end
    run(3 * FRAME);
  endtask

  initial begin
    n_vec = 0; n_err = 0; overlap = 0;
    for (int i = 0; i < 6; i++) en_hi[i] = 0;
    model_reset();
    test_reset();
    test_scan();
    test_mm_change();
    test_invalid();
    test_blank();
    test_random();
    test_back_to_back_frames();
    test_reset_mid_conv();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
